// File: rtl/led_pattern_gen.sv
// LED pattern generator: four animations (bounce, rotate, binary count,
// thermometer fill) stepped by a speed-selectable prescaler, controlled by
// three synchronised and debounced push-buttons (mode, speed, pause).
module led_pattern_gen #(
  parameter int NUM_LEDS        = 8,
  parameter int STEP_DIV        = 1048576,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_mode,
  input  logic                btn_speed,
  input  logic                btn_pause,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic [1:0]          speed,
  output logic                paused,
  output logic                step_tick
);

  localparam int PW   = $clog2(STEP_DIV);
  localparam int POSW = $clog2(NUM_LEDS);
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES);

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  localparam logic [NUM_LEDS-1:0] LED_ONE  = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] LED_ZERO = {NUM_LEDS{1'b0}};
  localparam logic [POSW-1:0]     POS_MAX  = POSW'(NUM_LEDS - 1);
  localparam logic [POSW-1:0]     POS_ZERO = {POSW{1'b0}};
  localparam logic [DBW-1:0]      DB_MAX   = DBW'(DEBOUNCE_CYCLES - 1);

  // Button vector index: 0 mode, 1 speed, 2 pause
  localparam int BTN_MODE  = 0;
  localparam int BTN_SPEED = 1;
  localparam int BTN_PAUSE = 2;

  // One-hot LED pattern for a bounce position
  function automatic logic [NUM_LEDS-1:0] onehot(input logic [POSW-1:0] p);
    onehot = LED_ONE << p;
  endfunction

  // Pattern shown right after entering a mode
  function automatic logic [NUM_LEDS-1:0] init_pattern(input logic [1:0] m);
    case (m)
      MODE_BOUNCE: init_pattern = LED_ONE;
      MODE_ROTATE: init_pattern = LED_ONE;
      MODE_COUNT:  init_pattern = LED_ZERO;
      MODE_FILL:   init_pattern = LED_ZERO;
      default:     init_pattern = LED_ONE;
    endcase
  endfunction

  logic [2:0]          btn_s;
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]          stable_q, stable_d;
  logic [2:0]          press_q, press_d;

  logic [PW-1:0]       presc_q, presc_d;
  logic [POSW-1:0]     pos_q, pos_d;
  logic                dir_q, dir_d;          // 0 = moving up, 1 = moving down
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          speed_q, speed_d;
  logic                paused_q, paused_d;
  logic                step_tick_q, step_tick_d;

  logic [PW:0]         period_s, period_m1_s;
  logic                presc_last_s, step_s;

  assign btn_s = {btn_pause, btn_speed, btn_mode};

  // Two-flop synchronisers for the asynchronous button pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= btn_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count while the synchronised level disagrees with the accepted one
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    press_d  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          stable_d[i] = sync2_q[i];
          db_cnt_d[i] = {DBW{1'b0}};
          press_d[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
        end
      end else begin
        db_cnt_d[i] = {DBW{1'b0}};
      end
    end
  end

  // Debounce state and registered press pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      stable_q <= 3'b000;
      press_q  <= 3'b000;
    end else begin
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  // Step period for the current speed and the step condition
  always_comb begin
    period_s     = (PW+1)'(STEP_DIV) >> speed_q;
    period_m1_s  = period_s - (PW+1)'(1);
    presc_last_s = ({1'b0, presc_q} == period_m1_s);
    step_s       = !paused_q && presc_last_s &&
                   !press_q[BTN_MODE] && !press_q[BTN_SPEED];
  end

  // Next-state logic for prescaler, animation and control registers
  always_comb begin
    presc_d     = presc_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    led_d       = led_q;
    mode_d      = mode_q;
    speed_d     = speed_q;
    paused_d    = paused_q;
    step_tick_d = 1'b0;

    // Prescaler: cleared by mode/speed presses, frozen while paused
    if (press_q[BTN_MODE] || press_q[BTN_SPEED]) begin
      presc_d = {PW{1'b0}};
    end else if (paused_q) begin
      presc_d = presc_q;
    end else if (presc_last_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Pattern: a mode press overrides any step on the same cycle
    if (press_q[BTN_MODE]) begin
      mode_d = mode_q + 2'd1;
      pos_d  = POS_ZERO;
      dir_d  = 1'b0;
      led_d  = init_pattern(mode_d);
    end else if (step_s) begin
      step_tick_d = 1'b1;
      case (mode_q)
        MODE_BOUNCE: begin
          if (!dir_q) begin
            if (pos_q == POS_MAX) begin
              dir_d = 1'b1;
              pos_d = pos_q - POSW'(1);
            end else begin
              pos_d = pos_q + POSW'(1);
            end
          end else begin
            if (pos_q == POS_ZERO) begin
              dir_d = 1'b0;
              pos_d = pos_q + POSW'(1);
            end else begin
              pos_d = pos_q - POSW'(1);
            end
          end
          led_d = onehot(pos_d);
        end
        MODE_ROTATE: led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
        MODE_COUNT:  led_d = led_q + LED_ONE;
        MODE_FILL: begin
          if (&led_q) begin
            led_d = LED_ZERO;
          end else begin
            led_d = {led_q[NUM_LEDS-2:0], 1'b1};
          end
        end
        default: led_d = led_q;
      endcase
    end else begin
      led_d = led_q;
    end

    if (press_q[BTN_SPEED]) begin
      speed_d = speed_q + 2'd1;
    end else begin
      speed_d = speed_q;
    end

    if (press_q[BTN_PAUSE]) begin
      paused_d = !paused_q;
    end else begin
      paused_d = paused_q;
    end
  end

  // Animation and control registers; all outputs come straight from here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= {PW{1'b0}};
      pos_q       <= POS_ZERO;
      dir_q       <= 1'b0;
      led_q       <= LED_ONE;
      mode_q      <= MODE_BOUNCE;
      speed_q     <= 2'd0;
      paused_q    <= 1'b0;
      step_tick_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      paused_q    <= paused_d;
      step_tick_q <= step_tick_d;
    end
  end

  assign led       = led_q;
  assign mode      = mode_q;
  assign speed     = speed_q;
  assign paused    = paused_q;
  assign step_tick = step_tick_q;

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator for the board-level demo top. It drives `NUM_LEDS` outputs with one of four selectable animations: bounce, rotate, binary count and thermometer fill. Steps advance at a prescaled rate with four speed settings. Three debounced push-buttons select the mode, cycle the speed and toggle pause; it sits directly between the board clock, the buttons and the LED pins.

## Interface
- `NUM_LEDS`, 8: number of LED outputs; must be ≥ 2.
- `STEP_DIV`, 1048576: clock cycles per animation step at speed 0; must be a power of two and ≥ 8.
- `DEBOUNCE_CYCLES`, 250000: cycles a synchronised button level must hold before it is accepted (10 ms at 25 MHz); must be ≥ 2.
- `clk`  in  1  board clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; the deassertion is synchronised externally.
- `btn_mode`  in  1  asynchronous, active-high; each press advances the mode.
- `btn_speed`  in  1  asynchronous, active-high; each press advances the speed.
- `btn_pause`  in  1  asynchronous, active-high; each press toggles pause.
- `led`  out  NUM_LEDS  registered pattern; a 1 means the LED is on.
- `mode`  out  2  current mode: 0 BOUNCE, 1 ROTATE, 2 COUNT, 3 FILL.
- `speed`  out  2  current speed level.
- `paused`  out  1  high while the animation is frozen.
- `step_tick`  out  1  registered one-cycle pulse on every animation step.

## Operation
- **Reset values:** `led`=1 (bit 0 set), `mode`=0, `speed`=0, `paused`=0, `step_tick`=0. Internal state also resets: prescaler=0, position=0, direction=up, debounced levels=0, sync flops=0.
- **Button path:** each button passes through a 2-FF synchroniser, then a debounce counter.
  - The counter increments while the synchronised value differs from the stable value, and clears whenever they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`-1, the stable value takes the synchronised value and the counter clears.
  - A press event is a one-cycle pulse on the stable 0→1 edge. Release generates nothing.
- **Prescaler:** width is $clog2(`STEP_DIV`). The step period is `STEP_DIV` >> `speed`.
  - The prescaler counts 0..period-1 while `paused`=0 and holds its value while `paused`=1.
  - At count = period-1 it wraps to 0 and a step occurs.
- **Step, by mode** (all arithmetic modulo the output width):
  - BOUNCE: one-hot at position p. p increments up to `NUM_LEDS`-1, then the direction flips and p decrements to 0, then flips again. There are no repeated end positions, so the cycle length is 2·`NUM_LEDS`-2.
  - ROTATE: one-hot; rotate left, so bit `NUM_LEDS`-1 wraps to bit 0.
  - COUNT: `led` = `led`+1, wrapping from all-ones to 0.
  - FILL: thermometer code with k low bits set, k = 0..`NUM_LEDS`. After all-ones, the next step gives 0. Cycle length is `NUM_LEDS`+1.
- **Mode press:** `mode` ← `mode`+1, wrapping 3→0. The prescaler, position and direction are cleared, and `led` loads the new mode's initial pattern: BOUNCE/ROTATE 1, COUNT/FILL 0. `paused` is unchanged.
- **Speed press:** `speed` ← `speed`+1, wrapping 3→0. The prescaler clears; `led` is unchanged.
- **Pause press:** `paused` toggles. While paused, `led`, the position and the prescaler hold, and `step_tick` stays 0.
- **Simultaneous events:**
  - A mode press and a step on the same cycle: the mode press wins; no step is taken and `step_tick`=0.
  - A speed press and a step on the same cycle: the speed press wins in the same way.
  - Mode and speed presses together: both are applied.
  - Pause and mode presses together: both are applied; the new initial pattern is shown and held frozen.
- **Reset mid-operation:** all state returns to the reset values immediately and asynchronously, including partial debounce counts.

## Timing
- A step updates `led` and raises `step_tick` on the same clock edge; `step_tick` is high for exactly one cycle.
- The first step after reset or after a prescaler clear comes period cycles after the clear edge.
- Button latency, from a clean pin transition to the press event: 2 sync cycles + `DEBOUNCE_CYCLES` cycles. The resulting `mode`/`speed`/`paused`/`led` update is on the next edge.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event.
- All outputs are driven directly from flops.

## Test plan
All scenarios use `NUM_LEDS`=4, `STEP_DIV`=8, `DEBOUNCE_CYCLES`=4.
- **Reset and BOUNCE:** release reset and run 56 cycles → `led` sequence 1,2,4,8,4,2,1,2 with a `step_tick` every 8 cycles.
- **Mode and wrap:** press `btn_mode` once → ROTATE; 4 steps give 2,4,8,1. Press again → COUNT; 16 steps pass F then 0. Press again → FILL: 1,3,7,F,0. Press again → `mode`=0, `led`=1.
- **Speed:** press `btn_speed` 3 times → `speed`=3, period 1, `step_tick` high every cycle. A fourth press → `speed`=0, period 8.
- **Pause:** press `btn_pause` mid-sequence → `led` and the prescaler freeze and `step_tick`=0 for 100 cycles. A second press → the sequence resumes from the held values.
- **Debounce:** a 3-cycle pulse on `btn_mode` → no change. A held level → exactly one `mode` increment, 7 cycles after the pin change (2 sync + 4 debounce + 1 update).
- **Collision and reset:** align a mode press with the cycle where the prescaler is 7 → no `step_tick`, `led` = the new initial pattern. Assert `rst_n` low mid-debounce → all outputs return to reset values immediately.
